// File: rtl/load_unit_pkg.sv
// Shared encodings for the load unit: access sizes,
// FSM states and the wait-counter width.
package load_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   // True when the access cannot be served by one aligned read.
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      case (size)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = lo[0];
         SIZE_WORD: misaligned = (lo != 2'b00);
         default:   misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half out of a little-endian
// word and sign- or zero-extends it to 32 bits.
module load_align_extend
   import load_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = word[{addr_lo, 3'b000} +: 8];
   assign half_v = addr_lo[1] ? word[31:16] : word[15:0];

   // Extend the selected lane according to size and sign.
   always_comb begin
      result = word;
      case (size)
         SIZE_BYTE:
            result = {{24{is_signed & byte_v[7]}}, byte_v};
         SIZE_HALF:
            result = {{16{is_signed & half_v[15]}}, half_v};
         default:
            result = word;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues one aligned read,
// extracts the lane and returns a one-cycle response.
module load_unit
   import load_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [4:0]            req_dest,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [4:0]            rsp_dest,
   output logic                  rsp_error,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [1:0]            lo_q;
   logic [1:0]            size_q;
   logic                  sign_q;
   logic [4:0]            dest_q;
   logic [DATA_WIDTH-1:0] ext_data;
   logic                  bad;
   logic                  timeout;

   assign bad     = misaligned(req_size, req_addr[1:0]);
   assign timeout = (cnt_q == CNT_LAST);

   load_align_extend u_ext (
      .word      (mem_rd_data),
      .addr_lo   (lo_q),
      .size      (size_q),
      .is_signed (sign_q),
      .result    (ext_data)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_d = bad ? RESP : ISSUE;
         end
         ISSUE: begin
            mem_rd_en = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (mem_rd_valid || timeout) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait-cycle counter, cleared on issue.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (state_q == ISSUE) begin
         cnt_q <= '0;
      end else if (state_q == WAIT && !mem_rd_valid
                   && !timeout) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Request latch, memory address and response registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lo_q      <= '0;
         size_q    <= '0;
         sign_q    <= 1'b0;
         dest_q    <= '0;
         mem_addr  <= '0;
         rsp_data  <= '0;
         rsp_dest  <= '0;
         rsp_error <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            lo_q   <= req_addr[1:0];
            size_q <= req_size;
            sign_q <= req_signed;
            dest_q <= req_dest;
            if (bad) begin
               rsp_data  <= '0;
               rsp_dest  <= req_dest;
               rsp_error <= 1'b1;
            end else begin
               mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
         end
         if (state_q == WAIT) begin
            if (mem_rd_valid) begin
               rsp_data  <= ext_data;
               rsp_dest  <= dest_q;
               rsp_error <= 1'b0;
            end else if (timeout) begin
               rsp_data  <= '0;
               rsp_dest  <= dest_q;
               rsp_error <= 1'b1;
            end
         end
      end
   end

endmodule
